// File: rtl/path_runner.sv
// path_runner: replays a solved maze path from (0,0), checking bounds, walls and a 255-move timeout.
// Define WALL_CHECK_EN to read the map (RD/Din) and reject moves into walls.
module path_runner (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [1:0] move,
    input  logic       Din,
    output logic       run,
    output logic       doneRun,
    output logic       RD,
    output logic [4:0] Xm,
    output logic [4:0] Ym,
    output logic [3:0] posX,
    output logic [3:0] posY,
    output logic [7:0] steps,
    output logic       arrived,
    output logic       fail
);
    typedef enum logic [2:0] {IDLE, REQ, STEP, FINISH, ERR} state_t;
    state_t     state_q, state_d;
    logic [3:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [7:0] steps_q, steps_d;
    logic       arrived_q, arrived_d, fail_q, fail_d, err_pulsed_q, err_pulsed_d;
    logic [4:0] cand_x, cand_y;
    logic       oob, wall, at_goal, reject;
`ifdef WALL_CHECK_EN
    assign wall = Din;
`else
    logic unused_din;
    assign unused_din = Din;
    assign wall = 1'b0;
`endif
    // A step below 0 wraps to 5'h1f, so bit 4 flags both underflow and overflow.
    always_comb begin
        cand_x  = {1'b0, pos_x_q} + (move == 2'b10 ? 5'd1 : move == 2'b01 ? 5'h1f : 5'd0);
        cand_y  = {1'b0, pos_y_q} + (move == 2'b00 ? 5'd1 : move == 2'b11 ? 5'h1f : 5'd0);
        oob     = cand_x[4] | cand_y[4];
        at_goal = cand_x == 5'd15 && cand_y == 5'd15;
        reject  = oob || wall || (steps_q == 8'hff && !at_goal);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            steps_q      <= '0;
            arrived_q    <= 1'b0;
            fail_q       <= 1'b0;
            err_pulsed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            steps_q      <= steps_d;
            arrived_q    <= arrived_d;
            fail_q       <= fail_d;
            err_pulsed_q <= err_pulsed_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        steps_d      = steps_q;
        arrived_d    = arrived_q;
        fail_d       = fail_q;
        err_pulsed_d = err_pulsed_q;
        case (state_q)
            IDLE: if (done && !arrived_q && !fail_q) begin
                state_d = REQ;
                pos_x_d = '0;
                pos_y_d = '0;
                steps_d = '0;
            end
            REQ: state_d = STEP;
            STEP: if (reject) begin
                state_d = ERR;
                fail_d  = 1'b1;
            end else begin
                pos_x_d = cand_x[3:0];
                pos_y_d = cand_y[3:0];
                steps_d = steps_q + 8'd1;
                if (at_goal) begin
                    state_d   = FINISH;
                    arrived_d = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            ERR: err_pulsed_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        run     = state_q == REQ;
        doneRun = state_q == FINISH || (state_q == ERR && !err_pulsed_q);
`ifdef WALL_CHECK_EN
        RD      = state_q == STEP;
`else
        RD      = 1'b0;
`endif
        Xm      = state_q == STEP ? {1'b0, cand_x[3:0]} : {1'b0, pos_x_q};
        Ym      = state_q == STEP ? {1'b0, cand_y[3:0]} : {1'b0, pos_y_q};
        posX    = pos_x_q;
        posY    = pos_y_q;
        steps   = steps_q;
        arrived = arrived_q;
        fail    = fail_q;
    end
endmodule
